// File: rtl/mux_pkg.sv
// Shared types and constants for the round-robin / priority channel mux.
package mux_pkg;

  localparam int MODE_RR   = 0;
  localparam int MODE_PRIO = 1;
  localparam int MAX_CH    = 16;

  // Grant vectors are carried at the maximum channel count; unused upper bits stay zero.
  typedef logic [MAX_CH-1:0] grant_t;

  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from rr_ptr, or lowest index wins.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  grant_t             elig,
  input  logic [SEL_W-1:0]   rr_ptr,
  input  logic               mode,
  output grant_t             grant
);

  grant_t w_mask;
  grant_t w_hi;
  grant_t w_src;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_CH; gi++) begin : g_mask
      assign w_mask[gi] = (int'(rr_ptr) <= gi);
    end
  endgenerate

  // Requests at or above the pointer take precedence; otherwise the scan wraps to index 0.
  assign w_hi  = elig & w_mask;
  assign w_src = (mode || (w_hi == '0)) ? elig : w_hi;
  assign grant = w_src & (~w_src + grant_t'(1));

endmodule

// File: rtl/mux_rr_pipe.sv
// N-channel valid/ready mux with round-robin or fixed-priority arbitration,
// optional forced channel, and a single registered output stage.
module mux_rr_pipe
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int SEL_W = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  force_en,
  input  logic [SEL_W-1:0]      force_sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  grant_t           w_elig;
  grant_t           w_grant;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gdata;
  logic [SEL_W-1:0] w_gidx;

  // An out-of-range force_sel matches no live channel, so nothing is eligible.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_CH; gi++) begin : g_elig
      if (gi < N_CH) begin : g_live
        assign w_elig[gi] = in_valid[gi] && (!force_en || (int'(force_sel) == gi));
      end else begin : g_pad
        assign w_elig[gi] = 1'b0;
      end
    end
  endgenerate

  rr_arbiter #(
    .SEL_W (SEL_W)
  ) u_arb (
    .elig   (w_elig),
    .rr_ptr (r_rr_ptr),
    .mode   (MODE == MODE_PRIO),
    .grant  (w_grant)
  );

  assign w_load   = !r_out_valid || out_ready;
  assign w_xfer   = !rst && w_load && (|w_grant);
  assign in_ready = (!rst && w_load) ? w_grant[N_CH-1:0] : '0;

  always_comb begin
    w_gdata = '0;
    w_gidx  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant[i]) w_gdata = in_data[i*WIDTH +: WIDTH];
    end
    for (int i = 0; i < MAX_CH; i++) begin
      if (w_grant[i]) w_gidx = SEL_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= w_xfer;
        if (w_xfer) begin
          r_out_data <= w_gdata;
          r_out_sel  <= w_gidx;
        end
      end
      if ((MODE == MODE_RR) && w_xfer) begin
        r_rr_ptr <= (w_gidx == SEL_W'(N_CH - 1)) ? '0 : w_gidx + SEL_W'(1);
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Drives three mux variants (4ch RR, 4ch priority, 3ch RR) from shared stimulus
// and compares each against a queue-free arithmetic reference model.
module tb_mux_rr_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        force_en;
  logic [1:0]  force_sel;
  logic        out_ready;

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [7:0]  od0, od1, od2;
  logic [1:0]  os0, os1, os2;
  logic        ov0, ov1, ov2;

  mux_rr_pipe #(.N_CH(4), .WIDTH(8), .MODE(0)) u_rr4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .force_en(force_en), .force_sel(force_sel),
    .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(out_ready)
  );

  mux_rr_pipe #(.N_CH(4), .WIDTH(8), .MODE(1)) u_pr4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .force_en(force_en), .force_sel(force_sel),
    .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(out_ready)
  );

  mux_rr_pipe #(.N_CH(3), .WIDTH(8), .MODE(0)) u_rr3 (
    .clk(clk), .rst(rst), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(rdy2),
    .force_en(force_en), .force_sel(force_sel),
    .out_data(od2), .out_sel(os2), .out_valid(ov2), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance
  int         nch [3] = '{4, 4, 3};
  int         prio[3] = '{0, 1, 0};
  int         m_ptr  [3];
  bit         m_valid[3];
  logic [7:0] m_data [3];
  int         m_sel  [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_rdy(input int k);
    case (k)
      0:       return 32'(rdy0);
      1:       return 32'(rdy1);
      default: return 32'(rdy2);
    endcase
  endfunction

  function automatic logic [31:0] obs_val(input int k);
    case (k)
      0:       return 32'(ov0);
      1:       return 32'(ov1);
      default: return 32'(ov2);
    endcase
  endfunction

  function automatic logic [31:0] obs_dat(input int k);
    case (k)
      0:       return 32'(od0);
      1:       return 32'(od1);
      default: return 32'(od2);
    endcase
  endfunction

  function automatic logic [31:0] obs_sel(input int k);
    case (k)
      0:       return 32'(os0);
      1:       return 32'(os1);
      default: return 32'(os2);
    endcase
  endfunction

  // Winner among eligible channels: scan order starts at the pointer (RR) or at 0 (priority).
  function automatic int pick(input int k);
    int n;
    int idx;
    n = nch[k];
    for (int j = 0; j < n; j++) begin
      idx = (prio[k] == 1) ? j : (m_ptr[k] + j) % n;
      if (in_valid[idx] && (!force_en || int'(force_sel) == idx)) return idx;
    end
    return -1;
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic cycle();
    int g  [3];
    bit ld [3];
    #1;
    for (int k = 0; k < 3; k++) begin
      ld[k] = !rst && (!m_valid[k] || out_ready);
      g[k]  = ld[k] ? pick(k) : -1;
      chk($sformatf("in_ready[%0d]", k), obs_rdy(k), (g[k] < 0) ? 32'd0 : (32'd1 << g[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_valid[k] = 0; m_data[k] = 8'h00; m_sel[k] = 0; m_ptr[k] = 0;
      end else if (ld[k]) begin
        m_valid[k] = (g[k] >= 0);
        if (g[k] >= 0) begin
          m_data[k] = in_data[g[k]*8 +: 8];
          m_sel[k]  = g[k];
          if (prio[k] == 0) m_ptr[k] = (g[k] + 1) % nch[k];
        end
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_valid[%0d]", k), obs_val(k), 32'(m_valid[k]));
      chk($sformatf("out_data[%0d]", k),  obs_dat(k), 32'(m_data[k]));
      chk($sformatf("out_sel[%0d]", k),   obs_sel(k), 32'(m_sel[k]));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  int exp_rr4[6] = '{0, 1, 2, 3, 0, 1};
  int exp_rr3[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; force_en = 1'b0; force_sel = '0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0; m_valid[k] = 0; m_data[k] = 8'h00; m_sel[k] = 0;
    end

    // Reset then idle
    do_reset();
    chk("reset_out_valid", 32'(ov0), 32'd0);
    chk("reset_out_data", 32'(od0), 32'd0);
    cycle();

    // Round-robin fairness, one word per cycle
    do_reset();
    in_data = 32'h44332211; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr4_seq_sel", 32'(os0), 32'(exp_rr4[i]));
      chk("rr4_seq_data", 32'(od0), 32'(8'h11 * (exp_rr4[i] + 1)));
      chk("rr3_seq_sel", 32'(os2), 32'(exp_rr3[i]));
    end

    // Stall hold with 8'h22 in the output register
    do_reset();
    cycle();
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_data", 32'(od0), 32'h22);
      chk("stall_ready", 32'(rdy0), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("unstall_sel", 32'(os0), 32'd2);
    chk("unstall_data", 32'(od0), 32'h33);

    // Fixed priority
    in_valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("prio_sel1", 32'(os1), 32'd1);
    end
    in_valid = 4'b0100;
    cycle();
    chk("prio_sel2", 32'(os1), 32'd2);

    // Force mode, including an out-of-range index on the 3-channel instance
    force_en = 1'b1; force_sel = 2'd3; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("force_sel_rr4", 32'(os0), 32'd3);
      chk("force_sel_pr4", 32'(os1), 32'd3);
      chk("force_oob_valid", 32'(ov2), 32'd0);
    end
    in_valid = 4'b0111;
    cycle();
    chk("force_drain_valid", 32'(ov0), 32'd0);
    force_en = 1'b0;

    // Wrap on 3 channels, then reset mid-stream
    do_reset();
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) cycle();
    chk("wrap_sel_rr3", 32'(os2), 32'd0);
    rst = 1'b1;
    cycle();
    chk("midrst_valid", 32'(ov2), 32'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_sel_rr3", 32'(os2), 32'd0);
    chk("post_rst_sel_rr4", 32'(os0), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      force_en  = ($urandom_range(0, 3) == 0);
      force_sel = 2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
